// File: rtl/v_hier_pkg.sv
// Shared constants, FSM state encoding and round-robin helper for the v_hier scheduler.
package v_hier_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;
  localparam int ID_W     = 2;
  localparam int LAT_W    = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Pointer to the requester after g; wraps 3 -> 0 through the natural ID_W overflow.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] g);
    return g + ID_W'(1);
  endfunction

endpackage

// File: rtl/v_hier_sched_if.sv
// Request/response handshake bundle between requesters, consumer and the scheduler.
interface v_hier_sched_if #(
  parameter int NREQ = v_hier_pkg::NREQ_DEF,
  parameter int W    = v_hier_pkg::W_DEF
);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ*W-1:0]           req_data;
  logic [NREQ-1:0]             req_ready;
  logic                        rsp_valid;
  logic [v_hier_pkg::ID_W-1:0] rsp_id;
  logic [W-1:0]                rsp_data;
  logic                        rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/v_hier_rr.sv
// Round-robin winner selection: first valid requester at or after the pointer, wrapping.
module v_hier_rr
  import v_hier_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [ID_W-1:0] i_rr_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_grant_idx,
  output logic            o_grant_any
);

  int w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    w_idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(i_rr_ptr) + k) % NREQ;
      if (!o_grant_any && i_req_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = ID_W'(w_idx);
        o_grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/v_hier_sched.sv
// Single-outstanding scheduler sharing one v_hier_sub among NREQ requesters.
//   state   | meaning
//   ST_IDLE | no operation in flight; grant round-robin winner
//   ST_WAIT | operand driven on sub_avec, counting down sub-block latency
//   ST_RESP | result presented on rsp_*, waiting for rsp_ready
module v_hier_sched
  import v_hier_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int W       = W_DEF,
  parameter int SUB_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  v_hier_sched_if.slave bus,
  output logic [W-1:0] sub_avec,
  input  logic [W-1:0] sub_qvec,
  output logic         busy
);

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_op_id;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [W-1:0]      r_op_data;
  logic [W-1:0]      r_rsp_data;

  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_grant_any;
  logic              w_accept;
  logic [W-1:0]      w_req_operand;

  v_hier_rr #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req_valid (bus.req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  assign w_accept      = (r_state == ST_IDLE) && w_grant_any;
  assign w_req_operand = bus.req_data[int'(w_grant_idx)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_op_id    <= '0;
      r_lat_cnt  <= '0;
      r_op_data  <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op_data <= w_req_operand;
            r_op_id   <= w_grant_idx;
            r_rr_ptr  <= rr_next(w_grant_idx);
            r_lat_cnt <= LAT_W'(SUB_LAT - 1);
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_rsp_data <= sub_qvec;
            r_state    <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The grant is combinational from req_valid, so it is gated by reset as well as by state.
  assign bus.req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_id    = r_op_id;
  assign bus.rsp_data  = r_rsp_data;
  assign sub_avec      = (r_state == ST_WAIT) ? r_op_data : '0;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_v_hier_sched.sv
// Directed bench for v_hier_sched with SUB_LAT = 1, 2 and 4 sharing one stimulus.
module tb_v_hier_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  s_req_valid;
  logic [15:0] s_req_data;
  logic        s_rsp_ready;

  logic [3:0]  sub_avec1, sub_avec2, sub_avec4;
  logic [3:0]  sub_qvec1, sub_qvec2, sub_qvec4;
  logic        busy1, busy2, busy4;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external v_hier_sub: rotate right by one, then xor 4'h9.
  function automatic logic [3:0] sub_model(input logic [3:0] a);
    return {a[0], a[3:1]} ^ 4'h9;
  endfunction

  v_hier_sched_if #(.NREQ(4), .W(4)) if1 ();
  v_hier_sched_if #(.NREQ(4), .W(4)) if2 ();
  v_hier_sched_if #(.NREQ(4), .W(4)) if4 ();

  assign if1.req_valid = s_req_valid;
  assign if1.req_data  = s_req_data;
  assign if1.rsp_ready = s_rsp_ready;
  assign if2.req_valid = s_req_valid;
  assign if2.req_data  = s_req_data;
  assign if2.rsp_ready = s_rsp_ready;
  assign if4.req_valid = s_req_valid;
  assign if4.req_data  = s_req_data;
  assign if4.rsp_ready = s_rsp_ready;

  assign sub_qvec1 = sub_model(sub_avec1);
  assign sub_qvec2 = sub_model(sub_avec2);
  assign sub_qvec4 = sub_model(sub_avec4);

  v_hier_sched #(.NREQ(4), .W(4), .SUB_LAT(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (if1),
    .sub_avec (sub_avec1), .sub_qvec (sub_qvec1), .busy (busy1)
  );

  v_hier_sched #(.NREQ(4), .W(4), .SUB_LAT(2)) dut (
    .clk (clk), .rst_n (rst_n), .bus (if2),
    .sub_avec (sub_avec2), .sub_qvec (sub_qvec2), .busy (busy2)
  );

  v_hier_sched #(.NREQ(4), .W(4), .SUB_LAT(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .bus (if4),
    .sub_avec (sub_avec4), .sub_qvec (sub_qvec4), .busy (busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if2.rsp_valid && cyc < 20);
    if (!if2.rsp_valid) check({tag, "_timeout"}, 32'(if2.rsp_valid), 32'd1);
  endtask

  task automatic wait_grant(input string tag, output logic [3:0] g);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (if2.req_ready == 4'b0 && cyc < 20);
    g = if2.req_ready;
    if (g == 4'b0) check({tag, "_timeout"}, 32'(g), 32'hF);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(if2.req_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(if2.rsp_valid), 32'h0);
    check({tag, "_rsp_id"},    32'(if2.rsp_id),    32'h0);
    check({tag, "_rsp_data"},  32'(if2.rsp_data),  32'h0);
    check({tag, "_sub_avec"},  32'(sub_avec2),     32'h0);
    check({tag, "_busy"},      32'(busy2),         32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         n_gr;
    int         n_rsp;
    int         last_c;
    int         gid[5];
    logic [3:0] rdat[4];
    logic [3:0] g;
    int         lat1, lat2, lat4;
    int         bad_av;

    gid  = '{0, 1, 2, 3, 0};
    rdat = '{4'hA, 4'hC, 4'h2, 4'hF};

    // Reset with every requester pending: nothing may be granted.
    rst_n       = 1'b0;
    s_req_valid = 4'hF;
    s_req_data  = 16'h0;
    s_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Single request from requester 2, operand 5.
    s_req_valid = 4'b0000;
    rst_n       = 1'b1;
    @(negedge clk);
    check("idle_no_req_ready", 32'(if2.req_ready), 32'h0);
    check("idle_no_req_busy",  32'(busy2),         32'h0);
    s_req_valid = 4'b0100;
    s_req_data  = 16'h0500;
    #1;
    check("single_grant", 32'(if2.req_ready), 32'h4);
    @(posedge clk);
    #1;
    s_req_valid = 4'b0000;
    @(negedge clk);
    check("single_t1_ready", 32'(if2.req_ready), 32'h0);
    check("single_t1_busy",  32'(busy2),         32'h1);
    check("single_t1_avec",  32'(sub_avec2),     32'h5);
    check("single_t1_rspv",  32'(if2.rsp_valid), 32'h0);
    @(negedge clk);
    check("single_t2_rspv",  32'(if2.rsp_valid), 32'h0);
    @(negedge clk);
    check("single_t3_rspv",  32'(if2.rsp_valid), 32'h1);
    check("single_t3_id",    32'(if2.rsp_id),    32'h2);
    check("single_t3_data",  32'(if2.rsp_data),  32'h3);
    check("single_t3_avec",  32'(sub_avec2),     32'h0);

    // All four pending from reset: order 0,1,2,3,0, one grant every 4 cycles.
    @(negedge clk);
    rst_n       = 1'b0;
    s_req_data  = 16'hC7A6;
    s_req_valid = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_gr   = 0;
    n_rsp  = 0;
    last_c = 0;
    for (int c = 0; c < 40 && n_gr < 5; c++) begin
      if (if2.rsp_valid && n_rsp < 4) begin
        check("rr_rsp_id",   32'(if2.rsp_id),   32'(gid[n_rsp]));
        check("rr_rsp_data", 32'(if2.rsp_data), 32'(rdat[n_rsp]));
        n_rsp++;
      end
      if (if2.req_ready != 4'b0) begin
        check("rr_grant", 32'(if2.req_ready), 32'(1) << gid[n_gr]);
        if (n_gr > 0) check("rr_gap", 32'(c - last_c), 32'd4);
        last_c = c;
        n_gr++;
      end
      if (n_gr < 5) begin
        @(negedge clk);
        #1;
      end
    end
    check("rr_grant_count", 32'(n_gr),  32'd5);
    check("rr_rsp_count",   32'(n_rsp), 32'd4);

    // Back-pressure: response held 10 cycles, no grants while in RESP.
    s_rsp_ready = 1'b0;
    wait_rsp("hold", cyc);
    check("hold_latency", 32'(cyc), 32'd3);
    for (int k = 0; k < 10; k++) begin
      check("hold_rspv",      32'(if2.rsp_valid), 32'h1);
      check("hold_id",        32'(if2.rsp_id),    32'h0);
      check("hold_data",      32'(if2.rsp_data),  32'hA);
      check("hold_req_ready", 32'(if2.req_ready), 32'h0);
      if (k < 9) @(negedge clk);
    end
    s_rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_next_grant", 32'(if2.req_ready), 32'h2);

    // Reset during WAIT discards the operation; next grant restarts at 0.
    @(negedge clk);
    check("midrst_busy", 32'(busy2),     32'h1);
    check("midrst_avec", 32'(sub_avec2), 32'hA);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    #1;
    check("midrst_grant0", 32'(if2.req_ready), 32'h1);
    @(posedge clk);
    #1;
    s_req_valid = 4'b1000;
    wait_rsp("midrst_rsp", cyc);
    check("midrst_latency", 32'(cyc),          32'd3);
    check("midrst_rsp_id",  32'(if2.rsp_id),   32'h0);
    check("midrst_rsp_dat", 32'(if2.rsp_data), 32'hA);

    // Wrap-around: grant 3, then only requester 1 pending, then pointer at 2.
    wait_grant("wrap_g3", g);
    check("wrap_g3", 32'(g), 32'h8);
    @(posedge clk);
    #1;
    s_req_valid = 4'b0010;
    wait_rsp("wrap_rsp3", cyc);
    check("wrap_rsp3_id",   32'(if2.rsp_id),   32'h3);
    check("wrap_rsp3_data", 32'(if2.rsp_data), 32'hF);
    wait_grant("wrap_g1", g);
    check("wrap_g1", 32'(g), 32'h2);
    @(posedge clk);
    #1;
    s_req_valid = 4'hF;
    wait_rsp("wrap_rsp1", cyc);
    check("wrap_rsp1_id",   32'(if2.rsp_id),   32'h1);
    check("wrap_rsp1_data", 32'(if2.rsp_data), 32'hC);
    wait_grant("wrap_ptr2", g);
    check("wrap_ptr2", 32'(g), 32'h4);

    // Latency sweep across SUB_LAT = 1, 2, 4 with operand 6.
    @(negedge clk);
    rst_n       = 1'b0;
    s_req_valid = 4'b0000;
    s_req_data  = 16'h0006;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_req_valid = 4'b0001;
    #1;
    check("sweep_grant_l1", 32'(if1.req_ready), 32'h1);
    check("sweep_grant_l2", 32'(if2.req_ready), 32'h1);
    check("sweep_grant_l4", 32'(if4.req_ready), 32'h1);
    @(posedge clk);
    #1;
    s_req_valid = 4'b0000;
    lat1   = -1;
    lat2   = -1;
    lat4   = -1;
    bad_av = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (if1.rsp_valid && lat1 < 0) lat1 = c;
      if (if2.rsp_valid && lat2 < 0) lat2 = c;
      if (if4.rsp_valid && lat4 < 0) lat4 = c;
      if (sub_avec1 !== ((c <= 1) ? 4'h6 : 4'h0)) bad_av++;
      if (sub_avec2 !== ((c <= 2) ? 4'h6 : 4'h0)) bad_av++;
      if (sub_avec4 !== ((c <= 4) ? 4'h6 : 4'h0)) bad_av++;
    end
    check("sweep_lat_l1",  32'(lat1),   32'd2);
    check("sweep_lat_l2",  32'(lat2),   32'd3);
    check("sweep_lat_l4",  32'(lat4),   32'd5);
    check("sweep_avec_window", 32'(bad_av), 32'd0);
    check("sweep_data_l1", 32'(if1.rsp_data), 32'hA);
    check("sweep_data_l4", 32'(if4.rsp_data), 32'hA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
